cp0_unit: RTL and testbench

- Coprocessor-0 for the pipelined MIPS core; sits in the M stage directly upstream of the M/W pipeline register.
- Holds SR, Cause, EPC and PRId, and services mfc0/mtc0/eret.
- Arbitrates hardware interrupts against synchronous exceptions carried down the pipe.
- Produces the IntReq flush consumed by the M/W register and the EPC value used for the eret redirect.

---
 rtl/cp0_unit.sv | 123 ++++++++++++
 tb/tb_cp0_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the pipelined MIPS core (M stage): SR, Cause, EPC, PRId,
// mfc0/mtc0/eret service and interrupt/exception arbitration.
// Optional macro CP0_COUNT_EN adds the free-running Count register (reg 9).
module cp0_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_0715,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC_M,
  input  logic        BD_M,
  input  logic [4:0]  ExcCode_M,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] HandlerPC,
  output logic [31:0] DOut
);

  localparam int unsigned DW = 32;
  localparam logic [4:0] REG_COUNT = 5'd9;
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;
  localparam logic [DW-1:0] WORD_MASK = 32'hFFFF_FFFC;

  logic [5:0]    im;
  logic          exl;
  logic          ie;
  logic          cause_bd;
  logic [5:0]    cause_ip;
  logic [4:0]    cause_exc;
  logic [DW-1:0] epc_q;
  logic          int_pending;
  logic          exc_pending;
  logic [DW-1:0] sr_word;
  logic [DW-1:0] cause_word;
  logic [DW-1:0] epc_next;
  logic [DW-1:0] count_word;

  // Arbitration: enabled interrupt beats a synchronous exception; EXL blocks both
  always_comb begin
    int_pending = ie & (|(im & HWInt));
    exc_pending = (ExcCode_M != 5'd0);
    IntReq      = ~exl & (int_pending | exc_pending);
    epc_next    = (BD_M ? (PC_M - 32'd4) : PC_M) & WORD_MASK;
  end

  // SR / Cause / EPC state
  always_ff @(posedge clk) begin
    if (reset) begin
      im        <= 6'd0;
      exl       <= 1'b0;
      ie        <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'd0;
      cause_exc <= 5'd0;
      epc_q     <= '0;
    end else begin
      cause_ip <= HWInt;
      if (IntReq) begin
        exl       <= 1'b1;
        cause_bd  <= BD_M;
        cause_exc <= int_pending ? 5'd0 : ExcCode_M;
        epc_q     <= epc_next;
      end else if (WE) begin
        if (A2 == REG_SR) begin
          im  <= DIn[15:10];
          exl <= DIn[1];
          ie  <= DIn[0];
        end else if (A2 == REG_EPC) begin
          epc_q <= DIn & WORD_MASK;
        end
      end else if (EXLClr) begin
        exl <= 1'b0;
      end
    end
  end

`ifdef CP0_COUNT_EN
  logic [DW-1:0] count_q;

  // Free-running cycle counter, software-loadable through mtc0 9
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (!IntReq && WE && (A2 == REG_COUNT)) begin
      count_q <= DIn;
    end else begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count_word = count_q;
`else
  assign count_word = '0;
`endif

  // mfc0 read mux; unimplemented registers read 0
  always_comb begin
    sr_word    = {16'd0, im, 8'd0, exl, ie};
    cause_word = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
    DOut       = '0;
    case (A1)
      REG_COUNT: DOut = count_word;
      REG_SR:    DOut = sr_word;
      REG_CAUSE: DOut = cause_word;
      REG_EPC:   DOut = epc_q;
      REG_PRID:  DOut = PRID_VALUE;
      default:   DOut = '0;
    endcase
  end

  assign EPC       = epc_q;
  assign HandlerPC = HANDLER_PC;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit (honours CP0_COUNT_EN if defined).
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, ExcCode_M;
  logic [31:0] DIn, PC_M;
  logic        WE, BD_M, EXLClr;
  logic [5:0]  HWInt;
  logic        IntReq;
  logic [31:0] EPC, HandlerPC, DOut;

  int n_checks = 0;
  int n_fail   = 0;

  cp0_unit dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .PC_M(PC_M), .BD_M(BD_M), .ExcCode_M(ExcCode_M), .HWInt(HWInt),
    .EXLClr(EXLClr), .IntReq(IntReq), .EPC(EPC), .HandlerPC(HandlerPC),
    .DOut(DOut)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    A1 = a;
    #1;
    chk(tag, DOut, exp);
  endtask

  initial begin
    reset = 1'b1; A1 = '0; A2 = '0; DIn = '0; WE = 1'b0; PC_M = '0;
    BD_M = 1'b0; ExcCode_M = '0; HWInt = '0; EXLClr = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("reset_intreq", 32'(IntReq), 32'd0);
    chk("reset_epc", EPC, 32'd0);
    chk("handler_pc", HandlerPC, 32'h0000_4180);
    rd("reset_sr", 5'd12, 32'd0);
    rd("reset_cause", 5'd13, 32'd0);

    // mtc0 SR: IM=000001, IE=1; same-cycle read returns old value
    WE = 1'b1; A2 = 5'd12; DIn = 32'hFFFF_0401;
    rd("sr_old_same_cycle", 5'd12, 32'd0);
    tick();
    WE = 1'b0;
    rd("sr_masked_write", 5'd12, 32'h0000_0401);
    rd("prid", 5'd15, 32'h0000_0715);
    rd("unimpl_reg3", 5'd3, 32'd0);

    // Hardware interrupt
    HWInt = 6'b000001; PC_M = 32'h0000_3010; BD_M = 1'b0;
    #1;
    chk("irq_intreq", 32'(IntReq), 32'd1);
    tick();
    chk("irq_epc", EPC, 32'h0000_3010);
    chk("irq_no_nest", 32'(IntReq), 32'd0);
    rd("irq_cause", 5'd13, 32'h0000_0400);
    rd("irq_sr_exl", 5'd12, 32'h0000_0403);

    // eret, drop HWInt
    HWInt = '0; EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    rd("eret_sr", 5'd12, 32'h0000_0401);

    // AdEL in delay slot
    ExcCode_M = 5'd4; PC_M = 32'h0000_3024; BD_M = 1'b1;
    #1;
    chk("exc_intreq", 32'(IntReq), 32'd1);
    tick();
    ExcCode_M = '0; BD_M = 1'b0;
    chk("exc_epc", EPC, 32'h0000_3020);
    rd("exc_cause", 5'd13, 32'h8000_0010);

    // Nested exception suppressed while EXL=1
    ExcCode_M = 5'd10; PC_M = 32'h0000_3100;
    #1;
    chk("nested_suppressed", 32'(IntReq), 32'd0);
    tick();
    ExcCode_M = '0;
    chk("nested_epc_kept", EPC, 32'h0000_3020);

    // eret with pending interrupt: fires only once EXL drops
    EXLClr = 1'b1; HWInt = 6'b000001;
    #1;
    chk("eret_cycle_no_irq", 32'(IntReq), 32'd0);
    tick();
    EXLClr = 1'b0;
    #1;
    chk("post_eret_irq", 32'(IntReq), 32'd1);

    // mtc0 EPC in the same cycle as a taken interrupt is dropped
    WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_5000; PC_M = 32'h0000_3040;
    tick();
    WE = 1'b0;
    chk("flush_drops_write", EPC, 32'h0000_3040);
    rd("flush_cause", 5'd13, 32'h0000_0400);

    HWInt = '0; EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;

    // mtc0 EPC aligns; same-cycle read sees old
    WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_5003;
    rd("epc_old_same_cycle", 5'd14, 32'h0000_3040);
    tick();
    chk("epc_write_aligned", EPC, 32'h0000_5000);

    // Cause is not software-writable
    A2 = 5'd13; DIn = 32'hFFFF_FFFF;
    tick();
    WE = 1'b0;
    rd("cause_readonly", 5'd13, 32'd0);

    // Interrupt wins over simultaneous exception: ExcCode recorded as 0
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0801;
    tick();
    WE = 1'b0;
    HWInt = 6'b000010; ExcCode_M = 5'd4; PC_M = 32'h0000_0200;
    tick();
    HWInt = '0; ExcCode_M = '0;
    rd("irq_beats_exc_cause", 5'd13, 32'h0000_0800);
    chk("irq_beats_exc_epc", EPC, 32'h0000_0200);

    // Reset mid-handler clears EXL and EPC, overrides a concurrent eret
    reset = 1'b1; EXLClr = 1'b1;
    tick();
    reset = 1'b0; EXLClr = 1'b0;
    rd("midreset_sr", 5'd12, 32'd0);
    chk("midreset_epc", EPC, 32'd0);

    // EPC wraps modulo 2^32 for a delay slot at PC 0
    ExcCode_M = 5'd1; PC_M = 32'd0; BD_M = 1'b1;
    #1;
    chk("wrap_intreq", 32'(IntReq), 32'd1);
    tick();
    ExcCode_M = '0; BD_M = 1'b0;
    chk("wrap_epc", EPC, 32'hFFFF_FFFC);
    rd("wrap_cause", 5'd13, 32'h8000_0004);
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;

    // Count register (reg 9)
    WE = 1'b1; A2 = 5'd9; DIn = 32'hFFFF_FFFE;
    tick();
    WE = 1'b0;
`ifdef CP0_COUNT_EN
    rd("count_loaded", 5'd9, 32'hFFFF_FFFE);
    tick();
    rd("count_inc", 5'd9, 32'hFFFF_FFFF);
    tick();
    rd("count_wrap", 5'd9, 32'h0000_0000);
`else
    rd("count_absent", 5'd9, 32'd0);
    tick();
    rd("count_absent_later", 5'd9, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
